// File: rtl/dpram_pipe_buf_pkg.sv
// Shared definitions for the dual-port pipelined buffer RAM.
//
// Contents:
//   COLL_WRITE_FIRST / COLL_READ_FIRST : values for the COLL_MODE parameter
//   clr_state_e                        : clear engine state encoding
package dpram_pipe_buf_pkg;

    // Same-cycle, same-address collision policy
    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    // Clear engine states
    typedef enum logic {
        ST_CLR_IDLE = 1'b0,
        ST_CLR_RUN  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dpram_pipe_buf_rd_pipe.sv
// dpram_rd_pipe: N_DELAY-stage data + valid delay line.
//
// The output holds its previous value whenever the arriving stage is
// invalid. Asynchronous active-low reset clears all valid bits and data.
//
// Ports:
//   clk    in   clock
//   rstn   in   asynchronous active-low reset
//   vld_i  in   input valid
//   data_i in   input data (DW bits)
//   vld_o  out  valid, N_DELAY cycles after vld_i
//   data_o out  data belonging to vld_o, held while vld_o is low
module dpram_rd_pipe #(
    parameter int DW      = 32,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);

    logic [N_DELAY-1:0] vld_q;
    logic [DW-1:0]      data_q [N_DELAY];

    // Each stage only loads when the data arriving at it is valid; this
    // gives hold-on-invalid at the output and avoids needless toggling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int k = 0; k < N_DELAY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                data_q[0] <= data_i;
            end
            for (int k = 1; k < N_DELAY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign vld_o  = vld_q[N_DELAY-1];
    assign data_o = data_q[N_DELAY-1];

endmodule

// File: rtl/dpram_pipe_buf.sv
// dpram_pipe_buf: simple dual-port buffer RAM (A writes, B reads) with
// per-byte write enables, configurable read latency with a valid strobe,
// defined same-address collision behaviour and a built-in clear engine.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   ena, wea, addra,  port A write: enable, per-lane enables, address, data
//   dia
//   enb, addrb        port B read: enable, address
//   dob, dob_vld      read data and its valid strobe (N_DELAY cycles later)
//   clr_req           start-clear pulse
//   clr_busy          clear engine active
//   clr_done          one-cycle pulse when the clear completes
module dpram_pipe_buf
    import dpram_pipe_buf_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            BW        = 8,
    parameter int            NBE       = DW / BW,
    parameter int            AW        = 16,
    parameter int            DEPTH     = 1 << AW,
    parameter int            N_DELAY   = 1,
    parameter int            COLL_MODE = COLL_WRITE_FIRST,
    parameter logic [DW-1:0] CLR_VAL   = '0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           ena,
    input  logic [NBE-1:0] wea,
    input  logic [AW-1:0]  addra,
    input  logic [DW-1:0]  dia,
    input  logic           enb,
    input  logic [AW-1:0]  addrb,
    output logic [DW-1:0]  dob,
    output logic           dob_vld,
    input  logic           clr_req,
    output logic           clr_busy,
    output logic           clr_done
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          clr_done_q, clr_done_d;

    logic           wr_en;
    logic [NBE-1:0] wr_be;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           rd_ok;
    logic [DW-1:0]  rd_word;

    // Clear engine state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_CLR_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Clear engine next state: one word per cycle, leaving on the last word
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_CLR_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR_RUN;
                    cnt_d   = '0;
                end
            end
            ST_CLR_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = ST_CLR_IDLE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = ST_CLR_IDLE;
        endcase
    end

    assign clr_busy = (state_q == ST_CLR_RUN);
    assign clr_done = clr_done_q;

    // Single physical write port: the clear engine owns it while running,
    // so port A writes are dropped for the whole clear.
    always_comb begin
        wr_en   = 1'b0;
        wr_be   = wea;
        wr_addr = addra;
        wr_data = dia;
        if (state_q == ST_CLR_RUN) begin
            wr_en   = 1'b1;
            wr_be   = '1;
            wr_addr = cnt_q;
            wr_data = CLR_VAL;
        end else if (ena && ({1'b0, addra} < DEPTH_X)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr[IDX_W-1:0]][i*BW +: BW] <= wr_data[i*BW +: BW];
                end
            end
        end
    end

    assign rd_ok = ({1'b0, addrb} < DEPTH_X);

    // Read word for stage 0; in write-first mode the lanes being written
    // this same cycle (by port A or the clear engine) are forwarded.
    always_comb begin
        rd_word = mem[addrb[IDX_W-1:0]];
        if ((COLL_MODE == COLL_WRITE_FIRST) && wr_en && (wr_addr == addrb)) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*BW +: BW] = wr_data[i*BW +: BW];
                end
            end
        end
        if (!rd_ok) begin
            rd_word = '0;
        end
    end

    dpram_rd_pipe #(
        .DW      (DW),
        .N_DELAY (N_DELAY)
    ) u_rd_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .vld_i  (enb),
        .data_i (rd_word),
        .vld_o  (dob_vld),
        .data_o (dob)
    );

endmodule

// File: tb/tb_dpram_pipe_buf.sv
// Self-checking bench for dpram_pipe_buf. Two instances share all inputs:
// dutA (N_DELAY=2, write-first) and dutB (N_DELAY=3, read-first), both
// DW=32, AW=9, DEPTH=256. Every read pushes expected words for both
// instances to a scoreboard; the monitor pops them when each output is due.
module tb_dpram_pipe_buf;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        ena    = 1'b0;
    logic [3:0]  wea    = 4'h0;
    logic [8:0]  addra  = '0;
    logic [31:0] dia    = '0;
    logic        enb    = 1'b0;
    logic [8:0]  addrb  = '0;
    logic        clrReq = 1'b0;

    logic [31:0] dobA, dobB;
    logic        vldA, vldB, busyA, busyB, doneA, doneB;

    typedef struct {
        int          due0;
        int          due1;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t        sb[$];
    int          head [2];
    logic [31:0] lastDob [2];
    logic [31:0] model [256];
    int          ecount  = 0;
    int          tests   = 0;
    int          fails   = 0;
    logic        mRun    = 1'b0;
    int          mCnt    = 0;
    logic        expDone = 1'b0;
    logic        doFinal = 1'b0;

    dpram_pipe_buf #(.DW(32), .BW(8), .AW(9), .DEPTH(256), .N_DELAY(2), .COLL_MODE(1)) dutA (
        .clk(clk), .rstn(rstn), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dobA), .dob_vld(vldA),
        .clr_req(clrReq), .clr_busy(busyA), .clr_done(doneA)
    );

    dpram_pipe_buf #(.DW(32), .BW(8), .AW(9), .DEPTH(256), .N_DELAY(3), .COLL_MODE(0)) dutB (
        .clk(clk), .rstn(rstn), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .dob(dobB), .dob_vld(vldB),
        .clr_req(clrReq), .clr_busy(busyB), .clr_done(doneB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int a);
        return {8'hA5, 8'(a), ~8'(a), 8'(a + 3)};
    endfunction

    // One clock cycle: scoreboard the read (if any) against the memory as
    // it stands before the edge, then apply write and clear-engine effects.
    task automatic applyStimulus();
        logic        wen;
        logic [3:0]  be;
        int          wa;
        logic [31:0] wd, oldW, fwdW;
        wen = 1'b0; be = 4'h0; wa = 0; wd = '0;
        if (rstn) begin
            if (mRun) begin
                wen = 1'b1; be = 4'hF; wa = mCnt; wd = '0;
            end else if (ena && addra < 9'd256) begin
                wen = 1'b1; be = wea; wa = int'(addra); wd = dia;
            end
            if (enb) begin
                oldW = (addrb < 9'd256) ? model[addrb[7:0]] : 32'h0;
                fwdW = oldW;
                if (wen && wa == int'(addrb)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) fwdW[i*8 +: 8] = wd[i*8 +: 8];
                    end
                end
                sb.push_back('{due0: ecount + 2, due1: ecount + 3, d0: fwdW, d1: oldW});
            end
        end
        @(posedge clk);
        ecount++;
        expDone = 1'b0;
        if (rstn) begin
            if (wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
                end
            end
            if (mRun) begin
                if (mCnt == 255) begin
                    mRun    = 1'b0;
                    expDone = 1'b1;
                end
                mCnt++;
            end else if (clrReq) begin
                mRun = 1'b1;
                mCnt = 0;
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Compare one read port against the head of its scoreboard lane
    task automatic checkOutput(input int p, input logic [31:0] d, input logic v);
        logic        expV;
        logic [31:0] expD;
        int          h, due;
        h    = head[p];
        expV = 1'b0;
        expD = lastDob[p];
        if (h < sb.size()) begin
            due = (p == 0) ? sb[h].due0 : sb[h].due1;
            if (due == ecount) begin
                expV = 1'b1;
                expD = (p == 0) ? sb[h].d0 : sb[h].d1;
            end
        end
        tests++;
        assert (v === expV) else begin
            fails++;
            $error("[TB] FAIL dob_vld%0d cycle %0d: got %b expected %b", p, ecount, v, expV);
        end
        tests++;
        assert (d === expD) else begin
            fails++;
            $error("[TB] FAIL dob%0d cycle %0d: got %h expected %h", p, ecount, d, expD);
        end
        if (expV) begin
            head[p]    = h + 1;
            lastDob[p] = expD;
        end
    endtask

    // Monitor: sample all outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (ecount > 0) begin
            if (!rstn) begin
                sb.delete();
                for (int p = 0; p < 2; p++) begin
                    head[p]    = 0;
                    lastDob[p] = '0;
                end
            end
            checkOutput(0, dobA, vldA);
            checkOutput(1, dobB, vldB);
            tests++;
            assert (busyA === mRun && busyB === mRun) else begin
                fails++;
                $error("[TB] FAIL clr_busy cycle %0d: got %b/%b expected %b", ecount, busyA, busyB, mRun);
            end
            tests++;
            assert (doneA === expDone && doneB === expDone) else begin
                fails++;
                $error("[TB] FAIL clr_done cycle %0d: got %b/%b expected %b", ecount, doneA, doneB, expDone);
            end
            if (doFinal) begin
                tests++;
                assert (head[0] === sb.size() && head[1] === sb.size()) else begin
                    fails++;
                    $error("[TB] FAIL drain: got %0d/%0d reads returned expected %0d", head[0], head[1], sb.size());
                end
            end
        end
    end

    task automatic writeWord(input int a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; addra = 9'(a); dia = d; wea = be;
        applyStimulus();
        ena = 1'b0;
    endtask

    task automatic readWord(input int a);
        enb = 1'b1; addrb = 9'(a);
        applyStimulus();
        enb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            head[p] = 0; lastDob[p] = '0;
        end
        for (int a = 0; a < 256; a++) model[a] = 'x;

        // Reset state
        idle(2);
        rstn = 1'b1;
        idle(1);

        // Basic write/read with latency and hold
        writeWord(5, 32'hDEADBEEF, 4'hF);
        readWord(5);
        idle(5);

        // Byte enables
        writeWord(3, 32'h11223344, 4'hF);
        writeWord(3, 32'hAABBCCDD, 4'b0101);
        readWord(3);
        idle(4);

        // Same-cycle collision at 7, then read-after-write
        writeWord(7, 32'h0, 4'hF);
        ena = 1'b1; wea = 4'b1100; addra = 9'd7; dia = 32'hFFFF0000;
        enb = 1'b1; addrb = 9'd7;
        applyStimulus();
        ena = 1'b0;
        readWord(7);
        idle(4);

        // Fill with pattern, then out-of-range write and reads
        for (int a = 0; a < 256; a++) writeWord(a, pattern(a), 4'hF);
        writeWord(300, 32'h12345678, 4'hF);
        readWord(44);
        readWord(300);
        readWord(511);
        idle(4);

        // Full clear with dropped writes, an ignored clr_req and reads
        clrReq = 1'b1;
        applyStimulus();
        clrReq = 1'b0;
        for (int j = 0; j < 256; j++) begin
            if (j == 50) begin
                ena = 1'b1; addra = 9'd10; dia = 32'h55; wea = 4'hF;
            end
            if (j == 60) begin
                clrReq = 1'b1;
                ena = 1'b1; addra = 9'd11; dia = 32'h77; wea = 4'hF;
            end
            if (j == 20)  begin enb = 1'b1; addrb = 9'd5;   end
            if (j == 30)  begin enb = 1'b1; addrb = 9'd30;  end
            if (j == 200) begin enb = 1'b1; addrb = 9'd250; end
            applyStimulus();
            ena = 1'b0; enb = 1'b0; clrReq = 1'b0;
        end
        idle(2);

        // Streaming readback of every word
        for (int a = 0; a < 256; a++) begin
            enb = 1'b1; addrb = 9'(a);
            applyStimulus();
        end
        enb = 1'b0;
        idle(4);

        // Refill, then reset at clear cycle 100 with reads in flight
        for (int a = 0; a < 256; a++) writeWord(a, pattern(a), 4'hF);
        clrReq = 1'b1;
        applyStimulus();
        clrReq = 1'b0;
        for (int j = 0; j < 100; j++) begin
            enb = (j >= 97);
            addrb = 9'(j + 150);
            applyStimulus();
        end
        enb  = 1'b0;
        rstn = 1'b0;
        mRun = 1'b0;
        mCnt = 0;
        expDone = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(2);
        for (int a = 0; a < 256; a++) begin
            enb = 1'b1; addrb = 9'(a);
            applyStimulus();
        end
        enb = 1'b0;
        idle(5);

        doFinal = 1'b1;
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
